// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C responder: FSM state encoding,
// synchronizer depth and the bus ACK/NACK levels.
package i2c_pkg;

    localparam int   I2C_SYNC_STAGES = 2;
    localparam logic I2C_ACK         = 1'b0;
    localparam logic I2C_NACK        = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX_BYTE,
        ST_ACK_RX,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the asynchronous SCL/SDA lines into clk and derives SCL edges
// plus START/STOP conditions from the synchronized levels.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    logic [I2C_SYNC_STAGES-1:0] scl_pipe;
    logic [I2C_SYNC_STAGES-1:0] sda_pipe;
    logic                       scl_d;
    logic                       sda_d;
    logic                       scl_sync;
    logic                       sda_sync;

    // Reset to the idle-bus level so no phantom edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[I2C_SYNC_STAGES-2:0], scl_in};
            sda_pipe <= {sda_pipe[I2C_SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync;
            sda_d    <= sda_sync;
        end
    end

    assign scl_sync  = scl_pipe[I2C_SYNC_STAGES-1];
    assign sda_sync  = sda_pipe[I2C_SYNC_STAGES-1];
    assign scl_rise  = scl_sync & ~scl_d;
    assign scl_fall  = ~scl_sync & scl_d;
    assign start_det = scl_sync & scl_d & sda_d & ~sda_sync;
    assign stop_det  = scl_sync & scl_d & ~sda_d & sda_sync;
    assign sda       = sda_sync;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a fixed 7-bit address: ACKs every write byte, serves read
// bytes from user logic, never stretches the clock.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | bus free or block not addressed since reset
// ST_ADDR     | shifting in {addr, rw} after START
// ST_ACK_ADDR | driving the address ACK slot (ack_phase=1 while low)
// ST_RX_BYTE  | shifting in a write byte
// ST_ACK_RX   | driving the ACK slot for a received byte
// ST_TX_BYTE  | presenting a read byte MSB first on each SCL fall
// ST_TX_ACK   | sampling master ACK/NACK; ack_phase=1 waits to load next byte
// ST_IGNORE   | not ours or master NACKed; wait for START/STOP
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda;

    i2c_state_e state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic       rw, rw_nxt;
    logic       ack_phase, ack_phase_nxt;
    logic       sda_low, sda_low_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt;
    logic       tx_req_nxt;
    logic       busy_nxt;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (i2c_scl),
        .sda_in    (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda       (sda)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            sda_low   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            rw        <= rw_nxt;
            ack_phase <= ack_phase_nxt;
            sda_low   <= sda_low_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        rw_nxt        = rw;
        ack_phase_nxt = ack_phase;
        sda_low_nxt   = sda_low;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        busy_nxt      = busy;

        // Bus conditions win over any SCL edge seen in the same cycle.
        if (start_det) begin
            state_nxt     = ST_ADDR;
            bit_cnt_nxt   = 3'd0;
            sda_low_nxt   = 1'b0;
            ack_phase_nxt = 1'b0;
            busy_nxt      = 1'b0;
        end else if (stop_det) begin
            state_nxt     = ST_IDLE;
            sda_low_nxt   = 1'b0;
            ack_phase_nxt = 1'b0;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift_reg[6:0], sda};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw_nxt        = sda;
                            ack_phase_nxt = 1'b0;
                            if (shift_reg[6:0] == SLAVE_ADDR) begin
                                state_nxt = ST_ACK_ADDR;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ACK_ADDR, ST_ACK_RX: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_nxt = 1'b1;
                            sda_low_nxt   = 1'b1;
                            tx_req_nxt    = (state == ST_ACK_ADDR) && rw;
                        end else begin
                            ack_phase_nxt = 1'b0;
                            bit_cnt_nxt   = 3'd0;
                            if (state == ST_ACK_ADDR && rw) begin
                                // Closing fall of the ACK slot opens bit 7 of the read byte.
                                state_nxt   = ST_TX_BYTE;
                                shift_nxt   = tx_data;
                                sda_low_nxt = ~tx_data[7];
                            end else begin
                                state_nxt   = ST_RX_BYTE;
                                sda_low_nxt = 1'b0;
                            end
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift_reg[6:0], sda};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_nxt   = {shift_reg[6:0], sda};
                            rx_valid_nxt  = 1'b1;
                            state_nxt     = ST_ACK_RX;
                            ack_phase_nxt = 1'b0;
                        end
                    end
                end
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            sda_low_nxt   = 1'b0;
                            state_nxt     = ST_TX_ACK;
                            ack_phase_nxt = 1'b0;
                        end else begin
                            shift_nxt   = {shift_reg[6:0], 1'b0};
                            sda_low_nxt = ~shift_reg[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (!ack_phase) begin
                        if (scl_rise) begin
                            if (sda == I2C_ACK) begin
                                tx_req_nxt    = 1'b1;
                                ack_phase_nxt = 1'b1;
                            end else begin
                                state_nxt = ST_IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        state_nxt     = ST_TX_BYTE;
                        shift_nxt     = tx_data;
                        sda_low_nxt   = ~tx_data[7];
                        ack_phase_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

I2C target (responder) that answers the team's I2C master on the shared open-drain `i2c_scl`/`i2c_sda` bus. It oversamples both bus lines with the system clock and detects START and STOP conditions. It matches a fixed 7-bit address, ACKs write bytes, hands them to user logic, and serves read bytes fetched from user logic. It is the DUT counterpart and bus-functional peer for the master-side `i2c_if` environment. It does not stretch the clock.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h50: 7-bit address this block responds to.

Ports:
- `clk` in 1: system clock; must be at least 16x the SCL frequency.
- `rst` in 1: synchronous, active-high reset.
- `i2c_scl` in 1 (wire): bus clock; sampled only, never driven.
- `i2c_sda` inout 1 (wire): open-drain data line; driven `1'b0` or `1'bz`, never `1'b1`.
- `rx_data` out 8: last byte written by the master; valid while `rx_valid` is high.
- `rx_valid` out 1: one-cycle pulse per received write byte.
- `tx_data` in 8: byte to return on the next read byte.
- `tx_req` out 1: one-cycle pulse requesting `tx_data` for the upcoming read byte.
- `busy` out 1: high from address match until STOP, START, or abandonment.

## Operation
- Synchronization: 2-flop synchronizer on SCL and SDA, plus one delay register for edge detection.
  - `scl_rise`, `scl_fall`: derived from synchronized SCL.
  - START: synchronized SDA falls while SCL is high.
  - STOP: synchronized SDA rises while SCL is high.
- FSM states: IDLE, ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, TX_ACK, IGNORE.
- START from any state:
  - bit counter cleared, SDA released, state goes to ADDR (repeated START supported).
- STOP from any state:
  - SDA released, state goes to IDLE, `busy` cleared.
- ADDR:
  - Shift SDA MSB-first on each `scl_rise`.
  - After 8 bits, {addr[6:0], rw} is complete.
  - Match on `addr == SLAVE_ADDR`: ACK_ADDR, `busy` set.
  - Mismatch: IGNORE; SDA never driven; only a START or STOP leaves IGNORE.
- ACK_ADDR:
  - Drive SDA low from the `scl_fall` after bit 8 until the next `scl_fall`.
  - On that closing `scl_fall`: go to RX_BYTE if rw=0, TX_BYTE if rw=1.
  - For rw=1, `tx_req` pulses on the `scl_fall` that opens ACK_ADDR.
- RX_BYTE:
  - Shift 8 bits on `scl_rise`.
  - On the 8th, load `rx_data` and pulse `rx_valid` in the same cycle.
  - Then go to ACK_RX.
- ACK_RX: same drive-low window as ACK_ADDR, then back to RX_BYTE. Every byte is ACKed.
- TX_BYTE:
  - `tx_data` is latched into the shift register on the `scl_fall` that closes the preceding ACK slot.
  - Each `scl_fall` presents the next bit, MSB first: drive low for 0, release for 1.
  - After bit 0's `scl_fall`, release SDA and go to TX_ACK.
- TX_ACK:
  - Sample SDA on `scl_rise`.
  - ACK (0): pulse `tx_req` immediately; the next byte is latched on the following `scl_fall`; back to TX_BYTE.
  - NACK (1): go to IGNORE; bus released; `busy` stays high until STOP/START.
- Bit counter: 3 bits, wraps 7→0 at each byte boundary.
- Simultaneous events:
  - START/STOP takes priority over `scl_rise`/`scl_fall` in the same cycle.
  - `rst` overrides everything.

## Timing
Reset values:
- `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0.
- SDA released; state IDLE.
- Reset mid-transfer releases SDA on the next clock. The block rejoins only at the next START.

Latency:
- Bus edge to internal event: 3 `clk` cycles (2 sync + 1 edge).
- SDA drive changes 1 cycle after the detected `scl_fall`. This gives hold at least 4 `clk` after the true SCL falling edge.
- `rx_valid`: 3 cycles after the SCL rising edge of bit 0 of each byte.

`tx_data` handshake:
- `tx_data` must be stable from `tx_req` + 1 cycle until the next detected `scl_fall`. This window is at least half an SCL period.
- There is no backpressure and no clock stretching.

## Structure
- Package `i2c_pkg`:
  - `i2c_state_e` enum.
  - `I2C_SYNC_STAGES`=2.
  - `I2C_ACK`=1'b0, `I2C_NACK`=1'b1.
- Sub-module `i2c_line_sync`:
  - Synchronizes SCL/SDA.
  - Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, and synchronized `sda`.
- Top level: FSM, shift register, counter, and `assign i2c_sda = sda_low ? 1'b0 : 1'bz;`.

## Test plan
- Write to 7'h50 with data 8'hA5 then 8'h3C, then STOP:
  - ACK seen on 3 slots.
  - `rx_valid` pulses twice with `rx_data` 8'hA5 then 8'h3C.
  - `busy` falls after STOP.
- Read from 7'h50 with `tx_data`=8'hC3, master ACKs, then `tx_data`=8'h0F, master NACKs, then STOP:
  - Bus shows 8'hC3 then 8'h0F.
  - `tx_req` pulses twice.
  - SDA released after NACK.
- Address 7'h51, rw=0, with `SLAVE_ADDR`=7'h50:
  - SDA never driven low; NACK seen.
  - No `rx_valid`; `busy` stays 0.
- Write 8'h11, then repeated START, then read with `tx_data`=8'h22:
  - `rx_data`=8'h11.
  - Read returns 8'h22 with no intervening STOP.
- Assert `rst` for 1 cycle while the block drives an ACK low:
  - SDA is 'z' on the next cycle and all outputs are at reset values.
  - The next full write of 8'h5A is ACKed and received.
